// File: rtl/tile_render_pkg.sv
// -----------------------------------------------------------------------------
// tile_render_pkg
//   Shared definitions for the tile/full-screen frame renderer:
//     - slot-state encoding (CLEAR/FADE/TARGET/HIT)
//     - ROM select codes: 0-3 tile sprites, 4-7 full-screen images
//     - renderer FSM state enum
// -----------------------------------------------------------------------------
package tile_render_pkg;

  typedef enum logic [1:0] {
    SLOT_CLEAR  = 2'd0,
    SLOT_FADE   = 2'd1,
    SLOT_TARGET = 2'd2,
    SLOT_HIT    = 2'd3
  } slot_state_e;

  localparam logic [2:0] ROM_SEL_CLEAR  = 3'd0;
  localparam logic [2:0] ROM_SEL_FADE   = 3'd1;
  localparam logic [2:0] ROM_SEL_TARGET = 3'd2;
  localparam logic [2:0] ROM_SEL_HIT    = 3'd3;
  localparam logic [2:0] ROM_SEL_TITLE1 = 3'd4;
  localparam logic [2:0] ROM_SEL_TITLE2 = 3'd5;
  localparam logic [2:0] ROM_SEL_WIN    = 3'd6;
  localparam logic [2:0] ROM_SEL_LOSE   = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_SCAN  = 3'd2,
    ST_FLUSH = 3'd3,
    ST_DONE  = 3'd4
  } render_state_e;

  // Tile sprites occupy the lower half of the ROM select space.
  function automatic logic [2:0] tile_rom_sel(input logic [1:0] state);
    return {1'b0, state};
  endfunction

  // Full-screen images occupy the upper half, in img_sel order.
  function automatic logic [2:0] image_rom_sel(input logic [1:0] img);
    return ROM_SEL_TITLE1 | {1'b0, img};
  endfunction

endpackage

// File: rtl/tile_scan_counter.sv
// -----------------------------------------------------------------------------
// tile_scan_counter
//   Nested x/y raster counter. x is the inner loop, y the outer loop; both
//   start at 0 and stop at their (inclusive) limit inputs.
// Ports
//   clk, resetn  clock, synchronous active-low reset
//   clear        force both counters to 0 (wins over step)
//   step         advance one position; ignored when already at the last one
//   x_last       inclusive x limit
//   y_last       inclusive y limit
//   cx, cy       current position
//   last         position is (x_last, y_last)
// -----------------------------------------------------------------------------
module tile_scan_counter #(
  parameter int XW = 9,
  parameter int YW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          clear,
  input  logic          step,
  input  logic [XW-1:0] x_last,
  input  logic [YW-1:0] y_last,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  logic row_end;

  assign row_end = (cx == x_last);
  assign last    = row_end && (cy == y_last);

  always_ff @(posedge clk) begin
    if (!resetn || clear) begin
      cx <= '0;
      cy <= '0;
    end else if (step && !last) begin
      if (row_end) begin
        cx <= '0;
        cy <= cy + 1'b1;
      end else begin
        cx <= cx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/tile_scan_renderer.sv
// -----------------------------------------------------------------------------
// tile_scan_renderer
//   Frame renderer for the VGA path. Each accepted start scans either one
//   full-screen image or a grid of NUM_SLOTS tiles and emits one x/y/colour
//   plot per pixel. Sprite ROMs are external (rom_sel/rom_addr in, rom_colour
//   back one cycle later).
//
//   Optional feature macro: TILE_DIRTY_SKIP_EN
//     When defined, slots whose state matches the last drawn state are skipped
//     with zero cycles. The stored state is invalidated by reset and by any
//     full-screen frame.
//
// Ports
//   clk, resetn   clock, synchronous active-low reset
//   start         begin a frame (dropped while busy or in DONE)
//   mode          1 = full-screen image, 0 = tile grid
//   img_sel       full-screen image: 0 title1, 1 title2, 2 win, 3 lose
//   slot_state    2 bits per slot, slot i at [2i+1:2i]
//   rom_sel       ROM select (0-3 tile sprite, 4-7 image)
//   rom_addr      ROM address, data returns on rom_colour next cycle
//   rom_colour    ROM read data
//   x, y, colour  plot coordinates and colour
//   plot          x/y/colour valid this cycle
//   busy          frame in progress (LATCH through FLUSH)
//   done          one-cycle pulse after the last plot
// -----------------------------------------------------------------------------
module tile_scan_renderer
  import tile_render_pkg::*;
#(
  parameter int SCREEN_W  = 320,
  parameter int SCREEN_H  = 240,
  parameter int TILE_W    = 60,
  parameter int TILE_H    = 80,
  parameter int GRID_COLS = 2,
  parameter int NUM_SLOTS = 6,
  parameter int X_PITCH   = 260,
  parameter int Y_PITCH   = 80
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        start,
  input  logic                        mode,
  input  logic [1:0]                  img_sel,
  input  logic [2*NUM_SLOTS-1:0]      slot_state,
  output logic [2:0]                  rom_sel,
  output logic [16:0]                 rom_addr,
  input  logic [2:0]                  rom_colour,
  output logic [$clog2(SCREEN_W)-1:0] x,
  output logic [$clog2(SCREEN_H)-1:0] y,
  output logic [2:0]                  colour,
  output logic                        plot,
  output logic                        busy,
  output logic                        done
);

  localparam int XW       = $clog2(SCREEN_W);
  localparam int YW       = $clog2(SCREEN_H);
  localparam int NUM_ROWS = (NUM_SLOTS + GRID_COLS - 1) / GRID_COLS;
  // Wide enough to hold NUM_SLOTS itself, so "no slot after this one" compares cleanly.
  localparam int SW       = $clog2(NUM_SLOTS + 1);

  if (NUM_SLOTS < 1 || NUM_SLOTS > 16 || GRID_COLS < 1 ||
      (GRID_COLS - 1) * X_PITCH + TILE_W > SCREEN_W ||
      (NUM_ROWS - 1) * Y_PITCH + TILE_H > SCREEN_H ||
      SCREEN_W * SCREEN_H > (1 << 17)) begin : g_bad_geometry
    $error("tile_scan_renderer: geometry puts a tile off screen or overflows rom_addr");
  end

  render_state_e         state;
  logic                  snap_mode;
  logic [1:0]            snap_img;
  logic [2*NUM_SLOTS-1:0] snap_slots;
  logic [SW-1:0]         slot;
  logic [XW-1:0]         base_x;
  logic [YW-1:0]         base_y;

  logic [XW-1:0] cnt_x;
  logic [YW-1:0] cnt_y;
  logic          cnt_last, cnt_clear, cnt_step;
  logic [XW-1:0] x_last;
  logic [YW-1:0] y_last;

  // Screen origin of each slot, stepped col/row counters (constant after elaboration).
  logic [XW-1:0] org_x [NUM_SLOTS];
  logic [YW-1:0] org_y [NUM_SLOTS];

  always_comb begin
    int col;
    int row;
    // NOTE: blocking assignments are correct here; col/row are combinational
    // temporaries that must update within the same loop iteration.
    col = 0;
    row = 0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      org_x[i] = XW'(col * X_PITCH);
      org_y[i] = YW'(row * Y_PITCH);
      if (col == GRID_COLS - 1) begin
        col = 0;
        row = row + 1;
      end else begin
        col = col + 1;
      end
    end
  end

  // Which slots of the latched snapshot need drawing this frame.
  logic [NUM_SLOTS-1:0] draw_mask;

`ifdef TILE_DIRTY_SKIP_EN
  logic [2*NUM_SLOTS-1:0] drawn_slots;
  logic                   drawn_valid;

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++)
      draw_mask[i] = !drawn_valid || (snap_slots[2*i +: 2] != drawn_slots[2*i +: 2]);
  end

  // NOTE: drawn_slots is storage, not control; only its valid flag needs reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      drawn_valid <= 1'b0;
    end else if (state == ST_LATCH) begin
      drawn_valid <= !snap_mode;
      if (!snap_mode)
        drawn_slots <= snap_slots;
    end
  end
`else
  assign draw_mask = '1;
`endif

  // Lowest slot to draw, and lowest slot to draw after the current one.
  logic [SW-1:0] first_slot, next_slot;
  logic          first_found, next_found;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    first_slot  = '0;
    first_found = 1'b0;
    next_slot   = '0;
    next_found  = 1'b0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (draw_mask[i]) begin
        first_slot  = SW'(i);
        first_found = 1'b1;
        if (SW'(i) > slot) begin
          next_slot  = SW'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  assign x_last    = snap_mode ? XW'(SCREEN_W - 1) : XW'(TILE_W - 1);
  assign y_last    = snap_mode ? YW'(SCREEN_H - 1) : YW'(TILE_H - 1);
  assign cnt_clear = (state == ST_LATCH) ||
                     (state == ST_SCAN && cnt_last && !snap_mode && next_found);
  assign cnt_step  = (state == ST_SCAN) && !cnt_last;

  tile_scan_counter #(.XW(XW), .YW(YW)) u_counter (
    .clk    (clk),
    .resetn (resetn),
    .clear  (cnt_clear),
    .step   (cnt_step),
    .x_last (x_last),
    .y_last (y_last),
    .cx     (cnt_x),
    .cy     (cnt_y),
    .last   (cnt_last)
  );

  // ROM data for the address issued last cycle arrives alongside the registered plot.
  assign colour = plot ? rom_colour : 3'd0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= ST_IDLE;
      snap_mode  <= 1'b0;
      snap_img   <= '0;
      snap_slots <= '0;
      slot       <= '0;
      base_x     <= '0;
      base_y     <= '0;
      rom_sel    <= '0;
      rom_addr   <= '0;
      x          <= '0;
      y          <= '0;
      plot       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      plot <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LATCH;
            busy       <= 1'b1;
            snap_mode  <= mode;
            snap_img   <= img_sel;
            snap_slots <= slot_state;
          end
        end

        ST_LATCH: begin
          rom_addr <= '0;
          if (snap_mode) begin
            rom_sel <= image_rom_sel(snap_img);
            base_x  <= '0;
            base_y  <= '0;
            state   <= ST_SCAN;
          end else if (first_found) begin
            slot    <= first_slot;
            rom_sel <= tile_rom_sel(snap_slots[2*first_slot +: 2]);
            base_x  <= org_x[first_slot];
            base_y  <= org_y[first_slot];
            state   <= ST_SCAN;
          end else begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end

        ST_SCAN: begin
          plot <= 1'b1;
          x    <= base_x + cnt_x;
          y    <= base_y + cnt_y;
          if (!cnt_last) begin
            rom_addr <= rom_addr + 1'b1;
          end else if (!snap_mode && next_found) begin
            slot     <= next_slot;
            rom_addr <= '0;
            rom_sel  <= tile_rom_sel(snap_slots[2*next_slot +: 2]);
            base_x   <= org_x[next_slot];
            base_y   <= org_y[next_slot];
          end else begin
            state <= ST_FLUSH;
          end
        end

        ST_FLUSH: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_scan_renderer.sv
// -----------------------------------------------------------------------------
// tb_tile_scan_renderer
//   Self-checking bench. The DUT runs with a scaled-down geometry of the same
//   shape as the default (two columns, three rows, last column flush with the
//   right edge, last row flush with the bottom) so full frames stay short.
//   A synchronous ROM model returns a colour that depends on both rom_sel and
//   rom_addr, so a wrong select or address shows up as a wrong plot colour.
// -----------------------------------------------------------------------------
module tb_tile_scan_renderer;

  localparam int SCREEN_W  = 40;
  localparam int SCREEN_H  = 30;
  localparam int TILE_W    = 8;
  localparam int TILE_H    = 10;
  localparam int GRID_COLS = 2;
  localparam int NUM_SLOTS = 6;
  localparam int X_PITCH   = 32;
  localparam int Y_PITCH   = 10;
  localparam int XW        = $clog2(SCREEN_W);
  localparam int YW        = $clog2(SCREEN_H);
  localparam int SLW       = 2 * NUM_SLOTS;
  localparam int TILE_PX   = TILE_W * TILE_H;
  localparam int FULL_PX   = SCREEN_W * SCREEN_H;

  logic           clk = 1'b0;
  logic           resetn = 1'b0;
  logic           start = 1'b0;
  logic           mode = 1'b0;
  logic [1:0]     img_sel = '0;
  logic [SLW-1:0] slot_state = '0;
  logic [2:0]     rom_sel;
  logic [16:0]    rom_addr;
  logic [2:0]     rom_colour = '0;
  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic [2:0]     colour;
  logic           plot, busy, done;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tile_scan_renderer #(
    .SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .TILE_W(TILE_W), .TILE_H(TILE_H),
    .GRID_COLS(GRID_COLS), .NUM_SLOTS(NUM_SLOTS), .X_PITCH(X_PITCH), .Y_PITCH(Y_PITCH)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .mode(mode), .img_sel(img_sel),
    .slot_state(slot_state), .rom_sel(rom_sel), .rom_addr(rom_addr),
    .rom_colour(rom_colour), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done)
  );

  function automatic logic [2:0] rom_data(input logic [2:0] sel, input logic [16:0] addr);
    return addr[2:0] ^ addr[5:3] ^ addr[8:6] ^ sel;
  endfunction

  always @(posedge clk) rom_colour <= rom_data(rom_sel, rom_addr);

  typedef struct {
    int x;
    int y;
    logic [2:0] colour;
  } plot_t;

  typedef struct {
    int   expected;
    int   plots;
    int   bad;
    int   dones;
    int   first_cyc;
    int   done_cyc;
    int   last_x;
    int   last_y;
    logic busy_at1;
    logic busy_at_done;
  } frame_t;

  plot_t          exp_q[$];
  logic           model_valid = 1'b0;
  logic [SLW-1:0] model_slots = '0;

  // Scoreboard fill: every plot the frame should produce, in order.
  task automatic expect_frame(input logic m, input logic [1:0] img,
                              input logic [SLW-1:0] slots, output int n);
    logic [1:0] st;
    bit draw;
    n = 0;
    if (m) begin
      for (int py = 0; py < SCREEN_H; py++)
        for (int px = 0; px < SCREEN_W; px++) begin
          exp_q.push_back('{px, py, rom_data(3'(4 + img), 17'(py * SCREEN_W + px))});
          n++;
        end
      model_valid = 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        st   = slots[2*s +: 2];
        draw = 1'b1;
`ifdef TILE_DIRTY_SKIP_EN
        draw = !model_valid || (st != model_slots[2*s +: 2]);
`endif
        if (draw)
          for (int ty = 0; ty < TILE_H; ty++)
            for (int tx = 0; tx < TILE_W; tx++) begin
              exp_q.push_back('{(s % GRID_COLS) * X_PITCH + tx, (s / GRID_COLS) * Y_PITCH + ty,
                                rom_data({1'b0, st}, 17'(ty * TILE_W + tx))});
              n++;
            end
      end
      model_valid = 1'b1;
      model_slots = slots;
    end
  endtask

  // Start one frame and watch it; cycle 1 is the cycle after start is sampled.
  task automatic run_frame(input logic m, input logic [1:0] img, input logic [SLW-1:0] slots,
                           input int restart_at, input int change_at,
                           input logic [SLW-1:0] new_slots,
                           output frame_t r, output string first_bad);
    plot_t e;
    int budget;
    exp_q.delete();
    expect_frame(m, img, slots, r.expected);
    r.plots = 0; r.bad = 0; r.dones = 0; r.first_cyc = -1; r.done_cyc = -1;
    r.last_x = -1; r.last_y = -1; r.busy_at1 = 1'bx; r.busy_at_done = 1'bx;
    first_bad = "none";
    budget = r.expected + 40;
    @(negedge clk);
    mode = m; img_sel = img; slot_state = slots; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 1; cyc <= budget; cyc++) begin
      if (cyc == 1) r.busy_at1 = busy;
      if (plot === 1'b1) begin
        r.plots++;
        if (r.first_cyc < 0) r.first_cyc = cyc;
        r.last_x = int'(x);
        r.last_y = int'(y);
        if (exp_q.size() == 0) begin
          if (r.bad == 0) first_bad = $sformatf("unexpected plot (%0d,%0d) at cycle %0d", x, y, cyc);
          r.bad++;
        end else begin
          e = exp_q.pop_front();
          if (x !== XW'(e.x) || y !== YW'(e.y) || colour !== e.colour) begin
            if (r.bad == 0)
              first_bad = $sformatf("plot %0d got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)",
                                    r.plots, x, y, colour, e.x, e.y, e.colour);
            r.bad++;
          end
        end
      end
      if (done === 1'b1) begin
        r.dones++;
        if (r.done_cyc < 0) begin
          r.done_cyc = cyc;
          r.busy_at_done = busy;
        end
      end
      start = (restart_at >= 0) && (cyc == restart_at || done === 1'b1);
      if (cyc == change_at) slot_state = new_slots;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({x, y, colour, plot, busy, done, rom_sel, rom_addr} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got x=%0d y=%0d colour=%0d plot=%b busy=%b done=%b rom_sel=%0d rom_addr=%0d, want all 0",
               x, y, colour, plot, busy, done, rom_sel, rom_addr);
    end
    resetn = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || plot !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_after_reset: got busy=%b plot=%b, want 0/0", busy, plot);
    end
    model_valid = 1'b0;
  endtask

  task automatic test_full_screen();
    frame_t r;
    string fb;
    run_frame(1'b1, 2'd2, '0, -1, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== FULL_PX) begin n_bad++; $display("FAIL full_plot_count: got %0d want %0d", r.plots, FULL_PX); end
    n_cmp++;
    if (r.bad !== 0) begin n_bad++; $display("FAIL full_plot_data: %0d bad plots, want 0; first: %s", r.bad, fb); end
    n_cmp++;
    if (r.first_cyc !== 3) begin n_bad++; $display("FAIL full_first_latency: got %0d want 3", r.first_cyc); end
    n_cmp++;
    if (r.last_x !== SCREEN_W - 1 || r.last_y !== SCREEN_H - 1) begin
      n_bad++; $display("FAIL full_last_plot: got (%0d,%0d) want (%0d,%0d)", r.last_x, r.last_y, SCREEN_W - 1, SCREEN_H - 1);
    end
    n_cmp++;
    if (r.done_cyc !== FULL_PX + 3) begin n_bad++; $display("FAIL full_done_cycle: got %0d want %0d", r.done_cyc, FULL_PX + 3); end
    n_cmp++;
    if (r.dones !== 1) begin n_bad++; $display("FAIL full_done_count: got %0d want 1", r.dones); end
    n_cmp++;
    if (r.busy_at1 !== 1'b1 || r.busy_at_done !== 1'b0) begin
      n_bad++; $display("FAIL full_busy: got latch=%b done=%b want 1/0", r.busy_at1, r.busy_at_done);
    end
  endtask

  task automatic test_tile_grid();
    frame_t r;
    string fb;
    run_frame(1'b0, 2'd0, 12'h0E4, -1, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== NUM_SLOTS * TILE_PX) begin n_bad++; $display("FAIL tile_plot_count: got %0d want %0d", r.plots, NUM_SLOTS * TILE_PX); end
    n_cmp++;
    if (r.bad !== 0) begin n_bad++; $display("FAIL tile_plot_data: %0d bad plots, want 0; first: %s", r.bad, fb); end
    n_cmp++;
    if (r.done_cyc !== NUM_SLOTS * TILE_PX + 3 || r.dones !== 1) begin
      n_bad++; $display("FAIL tile_done: got cycle %0d count %0d want cycle %0d count 1", r.done_cyc, r.dones, NUM_SLOTS * TILE_PX + 3);
    end
  endtask

  task automatic test_back_to_back();
    frame_t r;
    string fb;
    run_frame(1'b1, 2'd1, '0, 200, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== FULL_PX) begin n_bad++; $display("FAIL restart_plot_count: got %0d want %0d", r.plots, FULL_PX); end
    n_cmp++;
    if (r.dones !== 1) begin n_bad++; $display("FAIL restart_done_count: got %0d want 1", r.dones); end
    n_cmp++;
    if (r.bad !== 0) begin n_bad++; $display("FAIL restart_plot_data: %0d bad plots, want 0; first: %s", r.bad, fb); end
  endtask

  task automatic test_midframe_change();
    frame_t r;
    string fb;
    int want;
    run_frame(1'b0, 2'd0, 12'h0E4, -1, 100, 12'h1E4, r, fb);
    n_cmp++;
    if (r.plots !== NUM_SLOTS * TILE_PX || r.bad !== 0) begin
      n_bad++; $display("FAIL snapshot_frame: got %0d plots %0d bad want %0d plots 0 bad; first: %s", r.plots, r.bad, NUM_SLOTS * TILE_PX, fb);
    end
`ifdef TILE_DIRTY_SKIP_EN
    want = TILE_PX;
`else
    want = NUM_SLOTS * TILE_PX;
`endif
    run_frame(1'b0, 2'd0, 12'h1E4, -1, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== want) begin n_bad++; $display("FAIL new_value_plot_count: got %0d want %0d", r.plots, want); end
    n_cmp++;
    if (r.bad !== 0) begin n_bad++; $display("FAIL new_value_plot_data: %0d bad plots, want 0; first: %s", r.bad, fb); end
  endtask

  task automatic test_dirty_skip();
    frame_t r;
    string fb;
    int want;
`ifdef TILE_DIRTY_SKIP_EN
    want = 0;
`else
    want = NUM_SLOTS * TILE_PX;
`endif
    run_frame(1'b0, 2'd0, 12'h1E4, -1, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== want || r.bad !== 0) begin
      n_bad++; $display("FAIL repeat_frame_plots: got %0d plots %0d bad want %0d plots 0 bad; first: %s", r.plots, r.bad, want, fb);
    end
    n_cmp++;
    if (r.done_cyc !== ((want == 0) ? 2 : want + 3) || r.dones !== 1) begin
      n_bad++; $display("FAIL repeat_frame_done: got cycle %0d count %0d want cycle %0d count 1",
                        r.done_cyc, r.dones, (want == 0) ? 2 : want + 3);
    end
  endtask

  task automatic test_reset_mid_frame();
    int plots, extra_plots, extra_dones;
    logic plot_after, busy_after;
    frame_t r;
    string fb;
    plots = 0;
    @(negedge clk);
    mode = 1'b1; img_sel = 2'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (plot === 1'b1) plots++;
      if (plots == 100) break;
      @(negedge clk);
    end
    n_cmp++;
    if (plots !== 100) begin n_bad++; $display("FAIL reset_mid_reach_100: got %0d plots want 100", plots); end
    resetn = 1'b0;
    @(negedge clk);
    plot_after = plot;
    busy_after = busy;
    extra_dones = (done === 1'b1) ? 1 : 0;
    resetn = 1'b1;
    model_valid = 1'b0;
    n_cmp++;
    if (plot_after !== 1'b0 || busy_after !== 1'b0) begin
      n_bad++; $display("FAIL reset_mid_outputs: got plot=%b busy=%b want 0/0", plot_after, busy_after);
    end
    extra_plots = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      if (plot === 1'b1) extra_plots++;
      if (done === 1'b1) extra_dones++;
    end
    n_cmp++;
    if (extra_plots !== 0 || extra_dones !== 0) begin
      n_bad++; $display("FAIL reset_mid_quiet: got %0d plots %0d dones want 0/0", extra_plots, extra_dones);
    end
    run_frame(1'b0, 2'd0, 12'h1E4, -1, -1, '0, r, fb);
    n_cmp++;
    if (r.plots !== NUM_SLOTS * TILE_PX || r.bad !== 0) begin
      n_bad++; $display("FAIL reset_recovery_frame: got %0d plots %0d bad want %0d plots 0 bad; first: %s",
                        r.plots, r.bad, NUM_SLOTS * TILE_PX, fb);
    end
  endtask

  initial begin
    test_reset();
    test_full_screen();
    test_tile_grid();
    test_back_to_back();
    test_midframe_change();
    test_dirty_skip();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
